ps2_key_emitter: RTL and testbench
==================================

Name: ps2_key_emitter

Overview:
- Device-side PS/2 keyboard transmitter: takes ASCII characters over a valid/ready handshake and converts each to its set-2 scancode (inverse of the keyboard decode table).
- Emits the make code, then break prefix F0 and the code again, as PS/2 device-to-host frames on generated clock/data lines.
- Serves as the stimulus/loopback source for the keyboard receive path, so RSA plaintext can be injected without a physical keyboard.

Parameters:
- CLK_DIV, 2500: system cycles per PS/2 clock half-period (20 kHz at 100 MHz); legal range ≥2.
- GAP_CYCLES, 5000: idle cycles, both lines high, after each stop bit before the next frame or return to idle; legal range ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- char_valid  in  1  char_in holds a character to send.
- char_in  in  8  ASCII character.
- char_ready  out  1  block can accept a character this cycle.
- ps2_clk_o  out  1  PS/2 clock, idle high.
- ps2_data_o  out  1  PS/2 data, idle high.
- busy  out  1  high while a sequence is in progress, including the gaps.
- unmapped  out  1  one-cycle pulse: the accepted character has no scancode and was dropped.

Behaviour:
- Reset is asynchronous. All outputs go to these values immediately on reset assertion, including mid-frame; any partial sequence is discarded:
  - ps2_clk_o=1, ps2_data_o=1.
  - char_ready=1, busy=0, unmapped=0.
- Mapping (combinational on char_in, evaluated at acceptance):
  - 'A'-'Z' and 'a'-'z' use the same codes: A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A.
  - '0'-'9': 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46.
  - ' ' (0x20)=29.
  - Every other value is unmapped.
- Handshake:
  - Accept when char_valid && char_ready.
  - char_ready = (state==IDLE).
  - An unmapped character: unmapped pulses high the cycle after acceptance, no frames are sent, and char_ready stays 1.
- Byte sequence per mapped character: code, F0, code (byte index 0..2).
- Frame: 11 bits, sent in this order:
  - start bit 0;
  - data[0]..data[7], LSB first;
  - odd-parity bit, equal to ~^data;
  - stop bit 1.
- States and transitions:
  - IDLE: waits for acceptance → SETUP.
  - SETUP: drive the current bit on ps2_data_o with ps2_clk_o=1 for CLK_DIV cycles → CLK_LO.
  - CLK_LO: ps2_clk_o=0 for CLK_DIV cycles, data held constant. Then: next bit → SETUP; after the stop bit → GAP.
  - GAP: both lines high for GAP_CYCLES. Then: more bytes → SETUP; after the last byte → IDLE.
- Timing invariants:
  - ps2_data_o changes only while ps2_clk_o=1; the host samples on the falling edge.
  - Start bit appears on ps2_data_o in the cycle after acceptance.
  - Each bit lasts exactly 2·CLK_DIV cycles.
  - A mapped character occupies 3·(22·CLK_DIV + GAP_CYCLES) cycles from acceptance to char_ready=1.
- busy = (state!=IDLE). char_in is registered at acceptance; later changes to char_in are ignored.
- Counters are sized with $clog2 of the maximum count and wrap-safe; no counter exceeds its terminal value.
- Outputs are registered; no combinational path from inputs to ps2_clk_o or ps2_data_o.

Optional Feature:
- Macro PS2_BREAK_EN.
- Defined: sequence is code, F0, code (3 bytes) as above.
- Undefined: make code only (1 byte). Character duration becomes 22·CLK_DIV + GAP_CYCLES, and the byte index logic is removed.

Test Plan:
- Settings: CLK_DIV=4, GAP_CYCLES=10 for all scenarios.
- 'A' (0x41) → three frames:
  - data bits 0,0,1,1,1,0,0,0 with parity 0 (byte 1C);
  - then F0 with parity 1;
  - then 1C with parity 0;
  - char_ready returns 1 exactly 294 cycles after acceptance.
- 'z' (0x7A) → 1A, F0, 1A, identical to 'Z'. '0' (0x30) → 45 (parity 0), F0, 45.
- '#' (0x23) → unmapped=1 for one cycle, both PS/2 lines stay high throughout, char_ready=1 on the next cycle.
- char_valid held high with 'B' then 'C' back-to-back → char_ready=0 during 'B'. 'C' is accepted on the first IDLE cycle, and its start bit comes no earlier than GAP_CYCLES after 'B''s final stop bit.
- rst_n asserted during the F0 frame of 'E' → ps2_clk_o=1, ps2_data_o=1, busy=0 within the same cycle; after release, 'E' is sent fresh starting from 24.
- Build without PS2_BREAK_EN, send '5' → single frame 2E (0010_1110, parity 1), char_ready back after 98 cycles.

Source files
------------

// File: rtl/ps2_key_emitter.sv
// Device-side PS/2 keyboard transmitter: ASCII in, set-2 make/break frames out.
// Define PS2_BREAK_EN to send code, F0, code; otherwise only the make code is sent.
`timescale 1ns/1ps
module ps2_key_emitter #(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_in,
  output logic       char_ready,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       busy,
  output logic       unmapped
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    STOP_BIT = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    CLK_LO,
    GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    r_bit;
  logic [3:0]    w_bit_nxt;
  logic [7:0]    r_code;
  logic [7:0]    w_code_nxt;
  logic          r_clk;
  logic          w_clk_nxt;
  logic          r_data;
  logic          w_data_nxt;
  logic          r_unmapped;
  logic          w_unmapped_nxt;
  logic [8:0]    w_lookup;
  logic          w_mapped;
  logic [7:0]    w_code;
  logic [7:0]    w_byte;
  logic          w_last_byte;
`ifdef PS2_BREAK_EN
  logic [1:0]    r_byte;
  logic [1:0]    w_byte_nxt;
`endif

  // Result is {mapped, scancode}; upper and lower case letters share a code.
  function automatic logic [8:0] lookupCode(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: lookupCode = {1'b1, 8'h1C};
      8'h42, 8'h62: lookupCode = {1'b1, 8'h32};
      8'h43, 8'h63: lookupCode = {1'b1, 8'h21};
      8'h44, 8'h64: lookupCode = {1'b1, 8'h23};
      8'h45, 8'h65: lookupCode = {1'b1, 8'h24};
      8'h46, 8'h66: lookupCode = {1'b1, 8'h2B};
      8'h47, 8'h67: lookupCode = {1'b1, 8'h34};
      8'h48, 8'h68: lookupCode = {1'b1, 8'h33};
      8'h49, 8'h69: lookupCode = {1'b1, 8'h43};
      8'h4A, 8'h6A: lookupCode = {1'b1, 8'h3B};
      8'h4B, 8'h6B: lookupCode = {1'b1, 8'h42};
      8'h4C, 8'h6C: lookupCode = {1'b1, 8'h4B};
      8'h4D, 8'h6D: lookupCode = {1'b1, 8'h3A};
      8'h4E, 8'h6E: lookupCode = {1'b1, 8'h31};
      8'h4F, 8'h6F: lookupCode = {1'b1, 8'h44};
      8'h50, 8'h70: lookupCode = {1'b1, 8'h4D};
      8'h51, 8'h71: lookupCode = {1'b1, 8'h15};
      8'h52, 8'h72: lookupCode = {1'b1, 8'h2D};
      8'h53, 8'h73: lookupCode = {1'b1, 8'h1B};
      8'h54, 8'h74: lookupCode = {1'b1, 8'h2C};
      8'h55, 8'h75: lookupCode = {1'b1, 8'h3C};
      8'h56, 8'h76: lookupCode = {1'b1, 8'h2A};
      8'h57, 8'h77: lookupCode = {1'b1, 8'h1D};
      8'h58, 8'h78: lookupCode = {1'b1, 8'h22};
      8'h59, 8'h79: lookupCode = {1'b1, 8'h35};
      8'h5A, 8'h7A: lookupCode = {1'b1, 8'h1A};
      8'h30:        lookupCode = {1'b1, 8'h45};
      8'h31:        lookupCode = {1'b1, 8'h16};
      8'h32:        lookupCode = {1'b1, 8'h1E};
      8'h33:        lookupCode = {1'b1, 8'h26};
      8'h34:        lookupCode = {1'b1, 8'h25};
      8'h35:        lookupCode = {1'b1, 8'h2E};
      8'h36:        lookupCode = {1'b1, 8'h36};
      8'h37:        lookupCode = {1'b1, 8'h3D};
      8'h38:        lookupCode = {1'b1, 8'h3E};
      8'h39:        lookupCode = {1'b1, 8'h46};
      8'h20:        lookupCode = {1'b1, 8'h29};
      default:      lookupCode = 9'h000;
    endcase
  endfunction

  // Frame position 0 is the start bit, 1..8 the data LSB first, 9 odd parity, 10 stop.
  function automatic logic frameBit(input logic [3:0] idx, input logic [7:0] b);
    case (idx)
      4'd0:    frameBit = 1'b0;
      4'd1:    frameBit = b[0];
      4'd2:    frameBit = b[1];
      4'd3:    frameBit = b[2];
      4'd4:    frameBit = b[3];
      4'd5:    frameBit = b[4];
      4'd6:    frameBit = b[5];
      4'd7:    frameBit = b[6];
      4'd8:    frameBit = b[7];
      4'd9:    frameBit = ~^b;
      default: frameBit = 1'b1;
    endcase
  endfunction

  assign w_lookup = lookupCode(char_in);
  assign w_mapped = w_lookup[8];
  assign w_code   = w_lookup[7:0];

`ifdef PS2_BREAK_EN
  assign w_byte      = (r_byte == 2'd1) ? 8'hF0 : r_code;
  assign w_last_byte = (r_byte == 2'd2);
`else
  assign w_byte      = r_code;
  assign w_last_byte = 1'b1;
`endif

  // Next-state logic also computes the next line levels so both PS/2 outputs come straight from flops.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_code_nxt     = r_code;
    w_clk_nxt      = 1'b1;
    w_data_nxt     = 1'b1;
    w_unmapped_nxt = 1'b0;
`ifdef PS2_BREAK_EN
    w_byte_nxt     = r_byte;
`endif
    case (r_state)
      IDLE: begin
        if (char_valid) begin
          if (w_mapped) begin
            w_state_nxt = SETUP;
            w_code_nxt  = w_code;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_data_nxt  = 1'b0;
`ifdef PS2_BREAK_EN
            w_byte_nxt  = 2'd0;
`endif
          end else begin
            w_unmapped_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        w_data_nxt = r_data;
        if (r_cnt == DIV_LAST) begin
          w_state_nxt = CLK_LO;
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      CLK_LO: begin
        w_clk_nxt  = 1'b0;
        w_data_nxt = r_data;
        if (r_cnt == DIV_LAST) begin
          w_cnt_nxt = '0;
          w_clk_nxt = 1'b1;
          if (r_bit == STOP_BIT) begin
            w_state_nxt = GAP;
            w_data_nxt  = 1'b1;
          end else begin
            w_state_nxt = SETUP;
            w_bit_nxt   = r_bit + 4'd1;
            w_data_nxt  = frameBit(r_bit + 4'd1, w_byte);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (w_last_byte) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SETUP;
            w_bit_nxt   = '0;
            w_data_nxt  = 1'b0;
`ifdef PS2_BREAK_EN
            w_byte_nxt  = r_byte + 2'd1;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_code     <= '0;
      r_clk      <= 1'b1;
      r_data     <= 1'b1;
      r_unmapped <= 1'b0;
`ifdef PS2_BREAK_EN
      r_byte     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_code     <= w_code_nxt;
      r_clk      <= w_clk_nxt;
      r_data     <= w_data_nxt;
      r_unmapped <= w_unmapped_nxt;
`ifdef PS2_BREAK_EN
      r_byte     <= w_byte_nxt;
`endif
    end
  end

  assign char_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign ps2_clk_o  = r_clk;
  assign ps2_data_o = r_data;
  assign unmapped   = r_unmapped;

endmodule

// File: tb/tb_ps2_key_emitter.sv
// Testbench for ps2_key_emitter: directed characters, scoreboard of expected PS/2 bytes
// checked by a frame-decoding monitor. Honours PS2_BREAK_EN the same way as the design.
`timescale 1ns/1ps
module tb_ps2_key_emitter;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 10;
  localparam int FRAME_CYC  = 22 * CLK_DIV + GAP_CYCLES;
`ifdef PS2_BREAK_EN
  localparam int SEQ_CYCLES = 3 * FRAME_CYC;
  localparam int RST_AT     = 120;
`else
  localparam int SEQ_CYCLES = FRAME_CYC;
  localparam int RST_AT     = 22;
`endif
  localparam int WAIT_LIMIT = 2000;
  localparam int NVEC       = 11;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char_in;
  logic       char_ready;
  logic       ps2_clk_o;
  logic       ps2_data_o;
  logic       busy;
  logic       unmapped;

  int         nChecks = 0;
  int         nErrors = 0;
  int         cyc = 0;
  int         glitches = 0;
  logic [7:0] expQ[$];

  logic [7:0] vChar   [0:NVEC-1] = '{8'h41, 8'h7A, 8'h5A, 8'h30, 8'h23, 8'h20,
                                     8'h39, 8'h6D, 8'h35, 8'h7B, 8'h40};
  logic [7:0] vCode   [0:NVEC-1] = '{8'h1C, 8'h1A, 8'h1A, 8'h45, 8'h00, 8'h29,
                                     8'h46, 8'h3A, 8'h2E, 8'h00, 8'h00};
  bit         vMapped [0:NVEC-1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  ps2_key_emitter #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_valid(char_valid),
    .char_in   (char_in),
    .char_ready(char_ready),
    .ps2_clk_o (ps2_clk_o),
    .ps2_data_o(ps2_data_o),
    .busy      (busy),
    .unmapped  (unmapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic pushSeq(input logic [7:0] code);
    expQ.push_back(code);
`ifdef PS2_BREAK_EN
    expQ.push_back(8'hF0);
    expQ.push_back(code);
`endif
  endtask

  // Counts negedges with char_ready low; called on a negedge.
  task automatic waitIdle(output int n);
    n = 0;
    while (!char_ready && n < WAIT_LIMIT) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] code, input bit mapped);
    int n;
    @(negedge clk);
    waitIdle(n);
    char_valid = 1'b1;
    char_in    = c;
    @(posedge clk);
    if (mapped) pushSeq(code);
    @(negedge clk);
    char_valid = 1'b0;
    char_in    = 8'hFF;
    if (mapped) begin
      checkOutput("startBit", {ps2_clk_o, ps2_data_o, busy, unmapped}, 4'b1010);
      waitIdle(n);
      checkOutput("seqCycles", n, SEQ_CYCLES);
    end else begin
      checkOutput("unmappedPulse", {unmapped, char_ready, ps2_clk_o, ps2_data_o}, 4'b1111);
      @(negedge clk);
      checkOutput("unmappedEnd", {unmapped, char_ready}, 2'b01);
      n = 0;
      repeat (20) begin
        @(negedge clk);
        if (!(ps2_clk_o && ps2_data_o)) n++;
      end
      checkOutput("linesIdle", n, 0);
    end
  endtask

  // Monitor: decode frames on falling PS/2 clock edges and score them against expQ.
  initial begin
    int         nb;
    int         lastFall;
    bit         spErr;
    logic       pc;
    logic       pd;
    logic [10:0] fr;
    logic [7:0] e;
    nb = 0; lastFall = -1; spErr = 0; pc = 1'b1; pd = 1'b1; fr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; lastFall = -1; spErr = 0; pc = 1'b1; pd = 1'b1;
      end else begin
        if (!pc && !ps2_clk_o && (ps2_data_o !== pd)) glitches++;
        if (pc && !ps2_clk_o) begin
          if (nb == 0) begin
            spErr = 0;
            if (lastFall >= 0)
              checkOutput("interFrameGap", ((cyc - lastFall) >= (2 * CLK_DIV + GAP_CYCLES)), 1);
          end else if ((cyc - lastFall) != 2 * CLK_DIV) begin
            spErr = 1;
          end
          fr[nb]   = ps2_data_o;
          lastFall = cyc;
          nb++;
          if (nb == 11) begin
            nb = 0;
            checkOutput("bitPeriod", spErr, 0);
            if (expQ.size() == 0) begin
              nChecks++;
              nErrors++;
              $display("[TB] FAIL unexpectedFrame: got %03h, required no frame", fr);
            end else begin
              e = expQ.pop_front();
              checkOutput("frame", fr, {1'b1, ~^e, e, 1'b0});
            end
          end
        end
        pc = ps2_clk_o;
        pd = ps2_data_o;
      end
    end
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("resetState", {ps2_clk_o, ps2_data_o, char_ready, busy, unmapped}, 5'b11100);
    rst_n = 1'b1;
    $display("[TB] reset released");

    for (int i = 0; i < NVEC; i++) begin
      $display("[TB] sending char %02h", vChar[i]);
      applyStimulus(vChar[i], vCode[i], vMapped[i]);
    end

    $display("[TB] back-to-back B then C");
    @(negedge clk);
    waitIdle(n);
    char_valid = 1'b1;
    char_in    = 8'h42;
    @(posedge clk);
    pushSeq(8'h32);
    @(negedge clk);
    char_in = 8'h43;
    checkOutput("b2bReadyLow", char_ready, 0);
    waitIdle(n);
    checkOutput("b2bSeqB", n, SEQ_CYCLES);
    @(posedge clk);
    pushSeq(8'h21);
    @(negedge clk);
    char_valid = 1'b0;
    checkOutput("b2bAcceptC", {char_ready, ps2_clk_o, ps2_data_o}, 3'b010);
    waitIdle(n);
    checkOutput("b2bSeqC", n, SEQ_CYCLES);

    $display("[TB] reset in the middle of E");
    @(negedge clk);
    waitIdle(n);
    char_valid = 1'b1;
    char_in    = 8'h45;
    @(posedge clk);
    pushSeq(8'h24);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (RST_AT - 1) @(negedge clk);
    checkOutput("preResetLines", {ps2_clk_o, ps2_data_o, busy}, 3'b001);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncReset", {ps2_clk_o, ps2_data_o, busy, char_ready, unmapped}, 5'b11010);
    expQ.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h45, 8'h24, 1'b1);

    n = 0;
    while (expQ.size() != 0 && n < WAIT_LIMIT) begin
      n++;
      @(negedge clk);
    end
    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("dataStable", glitches, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
